stoch_signed_addsub_mat: RTL

//  Element-wise signed stochastic matrix adder/subtractor with a runtime mode select.

---
 rtl/stoch_signed_addsub_mat.sv | 124 ++++++++++++
 1 files changed

// File: rtl/stoch_signed_addsub_mat.sv
// -----------------------------------------------------------------------------
// stoch_signed_addsub_mat
//
// Element-wise signed stochastic matrix adder/subtractor. Every element carries
// a signed bitstream as a positive/negative channel pair (p/m). Each element
// produces the unscaled sum (MODE=0) or difference (MODE=1) of its A and B
// streams. Excess ones that cannot be emitted in the current cycle are held in
// a per-channel saturating counter. A pending positive one and a pending
// negative one cancel each other.
//
// Ports
//   CLK   : clock, rising-edge active
//   nRST  : asynchronous active-low reset
//   CLR   : synchronous clear of counters, outputs and SAT; wins over data
//   MODE  : 0 = Y = A + B, 1 = Y = A - B (applies to every element that cycle)
//   A_p/A_m, B_p/B_m : [NUM_ROWS][NUM_COLS] input channel bits
//   Y_p/Y_m          : [NUM_ROWS][NUM_COLS] registered result channel bits
//   SAT   : sticky flag, set when any counter clipped at its maximum
// -----------------------------------------------------------------------------
module stoch_signed_addsub_mat #(
  parameter int NUM_ROWS  = 2,
  parameter int NUM_COLS  = 2,
  parameter int CNT_WIDTH = 4
) (
  input  logic                               CLK,
  input  logic                               nRST,
  input  logic                               CLR,
  input  logic                               MODE,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]  A_p,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]  A_m,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]  B_p,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]  B_m,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0]  Y_p,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0]  Y_m,
  output logic                               SAT
);

  // One extra bit so counter + incoming ones never wraps before clipping.
  localparam int TW = CNT_WIDTH + 1;
  localparam logic [TW-1:0] MAX_T = {1'b0, {CNT_WIDTH{1'b1}}};

  // Clip a remaining count to the counter range.
  function automatic logic [CNT_WIDTH-1:0] clip_cnt(input logic [TW-1:0] v);
    return (v > MAX_T) ? {CNT_WIDTH{1'b1}} : v[CNT_WIDTH-1:0];
  endfunction

  // True when a remaining count does not fit, i.e. ones are being lost.
  function automatic logic is_clipped(input logic [TW-1:0] v);
    return v > MAX_T;
  endfunction

  logic [NUM_ROWS-1:0][NUM_COLS-1:0][CNT_WIDTH-1:0] c_p_q, c_p_d, nxt_c_p;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][CNT_WIDTH-1:0] c_m_q, c_m_d, nxt_c_m;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                y_p_q, y_p_d, nxt_y_p;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                y_m_q, y_m_d, nxt_y_m;
  logic                                             sat_q, sat_d;
  logic [NUM_ROWS*NUM_COLS-1:0]                     sat_hit;

  for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < NUM_COLS; gj++) begin : g_col
      logic [1:0]    in_p, in_m;
      logic [TW-1:0] t_p, t_m, r_p, r_m;
      logic          e_p, e_m;

      // Subtraction is addition with B's channels swapped.
      assign in_p = {1'b0, A_p[gi][gj]} + {1'b0, (MODE ? B_m[gi][gj] : B_p[gi][gj])};
      assign in_m = {1'b0, A_m[gi][gj]} + {1'b0, (MODE ? B_p[gi][gj] : B_m[gi][gj])};

      assign t_p = {1'b0, c_p_q[gi][gj]} + TW'(in_p);
      assign t_m = {1'b0, c_m_q[gi][gj]} + TW'(in_m);

      assign e_p = |t_p;
      assign e_m = |t_m;

      // Both channels consume one pending one; if both were pending they
      // cancel and neither output fires.
      assign r_p = t_p - TW'(e_p);
      assign r_m = t_m - TW'(e_m);

      assign nxt_y_p[gi][gj] = e_p & ~e_m;
      assign nxt_y_m[gi][gj] = e_m & ~e_p;
      assign nxt_c_p[gi][gj] = clip_cnt(r_p);
      assign nxt_c_m[gi][gj] = clip_cnt(r_m);
      assign sat_hit[gi*NUM_COLS+gj] = is_clipped(r_p) | is_clipped(r_m);
    end
  end

  always_comb begin
    c_p_d = nxt_c_p;
    c_m_d = nxt_c_m;
    y_p_d = nxt_y_p;
    y_m_d = nxt_y_m;
    sat_d = sat_q | (|sat_hit);
    if (CLR) begin
      c_p_d = '0;
      c_m_d = '0;
      y_p_d = '0;
      y_m_d = '0;
      sat_d = 1'b0;
    end
  end

  // ---- register stage: counters, outputs, sticky flag ----
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      c_p_q <= '0;
      c_m_q <= '0;
      y_p_q <= '0;
      y_m_q <= '0;
      sat_q <= 1'b0;
    end else begin
      c_p_q <= c_p_d;
      c_m_q <= c_m_d;
      y_p_q <= y_p_d;
      y_m_q <= y_m_d;
      sat_q <= sat_d;
    end
  end

  assign Y_p = y_p_q;
  assign Y_m = y_m_q;
  assign SAT = sat_q;

endmodule
